bf_program_loader: RTL and testbench
====================================

// Module: bf_program_loader
// PURPOSE
//  Writer side of the program-memory interface: turns operator key presses into 4-bit
//  BF opcodes and writes them sequentially into program memory, ending with stop (4'b1111).
//  Sits between the switch/key inputs and the program RAM write port. Runs while the
//  control FSM is in hold; the control FSM then fetches from address 1 upward.
// PARAMETERS
//  ADDR_W   8  program address width (matches 8-bit PC); MAX_ADDR = 2**ADDR_W-1
//  DEPTH_W  8  width of open-bracket nesting counter
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  resetn      in   1       asynchronous, active-low reset
//  start_load  in   1       begin new program (sync, level; acts while high)
//  cmd_in      in   4       opcode on switches, sampled on cmd_key press
//  cmd_key     in   1       "enter instruction" key, synchronised level, 1 = pressed
//  end_key     in   1       "program finished" key, synchronised level, 1 = pressed
//  prog_addr   out  ADDR_W  write address / next free address
//  prog_wdata  out  4       opcode being written
//  prog_we     out  1       program-memory write strobe, one cycle per write
//  prog_len    out  ADDR_W  instructions written, excluding stop
//  loading     out  1       1 in LOAD/WRITE/TERM
//  load_done   out  1       program terminated cleanly
//  err         out  1       load aborted
//  err_code    out  2       01 invalid opcode, 10 memory full, 11 unbalanced brackets
// BEHAVIOUR
//  Reset: state IDLE; prog_addr=1, prog_wdata=0, prog_we=0, prog_len=0, loading=0,
//   load_done=0, err=0, err_code=00, depth=0, key history regs=0.
//  Address 0 never written: control increments PC before first fetch.
//  Key press = rising edge of registered key level; one action per press; hold = no repeat.
//  States: IDLE, LOAD, WRITE, TERM, DONE, ERR.
//  IDLE/DONE/ERR: presses ignored; start_load -> LOAD with prog_addr=1, len=0, depth=0,
//   err/err_code/load_done cleared. DONE holds load_done=1; ERR holds err, err_code.
//  LOAD, start_load high: restart (same as above), any press that cycle discarded.
//  LOAD, cmd press (edge seen cycle N), checked in order:
//   cmd_in 1000..1110 -> ERR 01, no write.
//   cmd_in 1111 -> treated as end press.
//   ']' (0101) with depth==0, or '[' (0100) with depth at max -> ERR 11.
//   prog_addr==MAX_ADDR -> ERR 10 (MAX_ADDR reserved for stop).
//   else -> WRITE: cycle N+1 prog_we=1, prog_wdata=cmd_in captured at N.
//  WRITE exit (cycle N+2): prog_addr+1, prog_len+1, depth +1 for '[', -1 for ']'; -> LOAD.
//  LOAD, end press: depth!=0 -> ERR 11; else TERM: one cycle prog_we=1, wdata=1111 at
//   prog_addr; then DONE; prog_addr/prog_len not incremented.
//  cmd and end press same cycle: cmd processed, end press discarded (re-press needed).
//  start_load during WRITE/TERM: write completes, restart taken next cycle if still high.
//  prog_we never asserted outside WRITE/TERM; at most one write per press.
//  resetn low mid-write: prog_we drops immediately (async), all regs to reset values.
// TESTING
//  start_load; cmd 0010,0010,0110; end -> writes @1=2,@2=2,@3=6,@4=F; len=3; load_done=1.
//  cmd_key held 20 cycles with cmd 0001 -> exactly one write @1=1; prog_we high 1 cycle.
//  cmd 0100,0010,0101,0101 -> 3 writes, 4th press ERR err_code=11, no write @4.
//  cmd 0100 then end -> ERR 11, no 1111 written; start_load -> LOAD, err=0, prog_addr=1.
//  cmd 1010 -> ERR 01, prog_we stays 0; with ADDR_W=3, 6 valid cmds then 7th -> ERR 10.
//  resetn pulsed low during WRITE -> prog_we 0 same cycle, IDLE, prog_addr=1, len=0.

Source files
------------

// File: rtl/bf_program_loader.sv
// ---------------------------------------------------------------------------
// bf_program_loader
//
// Purpose:
//   Write side of the BF program memory. Turns operator key presses into
//   4-bit opcodes and writes them one after another from address 1 upward.
//   Each program ends with the stop opcode (4'b1111). Open brackets are
//   tracked, so a program with unbalanced '[' / ']' is rejected before it
//   can run. Address 0 is never written because the control FSM increments
//   the PC before its first fetch.
//
// Parameters:
//   ADDR_W   program address width; the top address is kept for the stop opcode
//   DEPTH_W  width of the open-bracket nesting counter
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   resetn      asynchronous active-low reset
//   start_load  level; while high it (re)starts a load from address 1
//   cmd_in      opcode on the switches, sampled when cmd_key is pressed
//   cmd_key     "enter instruction" key, synchronised level, 1 = pressed
//   end_key     "program finished" key, synchronised level, 1 = pressed
//   prog_addr   write address, which is also the next free address
//   prog_wdata  opcode being written
//   prog_we     write strobe, one cycle per accepted press
//   prog_len    number of instructions written, not counting stop
//   loading     high while a load is in progress (LOAD/WRITE/TERM)
//   load_done   program was terminated cleanly
//   err         load was aborted; err_code tells why
//   err_code    01 invalid opcode, 10 memory full, 11 unbalanced brackets
// ---------------------------------------------------------------------------
module bf_program_loader #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_load,
    input  logic [3:0]        cmd_in,
    input  logic              cmd_key,
    input  logic              end_key,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [3:0]        prog_wdata,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_len,
    output logic              loading,
    output logic              load_done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_TERM,
        S_DONE,
        S_ERR
    } state_e;

    // What the LOAD state does with this cycle's key presses.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_WRITE,
        ACT_TERM,
        ACT_ERR
    } action_e;

    localparam logic [3:0]         OP_OPEN     = 4'b0100;
    localparam logic [3:0]         OP_CLOSE    = 4'b0101;
    localparam logic [3:0]         OP_STOP     = 4'b1111;
    localparam logic [1:0]         ERR_OPCODE  = 2'b01;
    localparam logic [1:0]         ERR_FULL    = 2'b10;
    localparam logic [1:0]         ERR_BRACKET = 2'b11;
    localparam logic [ADDR_W-1:0]  ADDR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  MAX_ADDR    = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE   = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] MAX_DEPTH   = '1;

    state_e              state_q;
    logic [ADDR_W-1:0]   prog_addr_q;
    logic [3:0]          prog_wdata_q;
    logic                prog_we_q;
    logic [ADDR_W-1:0]   prog_len_q;
    logic                loading_q;
    logic                load_done_q;
    logic                err_q;
    logic [1:0]          err_code_q;
    logic [DEPTH_W-1:0]  depth_q;
    logic                cmd_key_q;
    logic                end_key_q;

    logic                cmd_press;
    logic                end_press;
    action_e             action;
    logic [1:0]          action_code;

    // A press is the 0->1 transition of the key level, so holding a key
    // down never repeats the action.
    assign cmd_press = cmd_key & ~cmd_key_q;
    assign end_press = end_key & ~end_key_q;

    // Classify the press seen in LOAD. A cmd press wins over a simultaneous
    // end press; the end press is then lost and has to be repeated.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        action      = ACT_NONE;
        action_code = 2'b00;
        if (cmd_press) begin
            if (cmd_in[3] && (cmd_in != OP_STOP)) begin
                action      = ACT_ERR;
                action_code = ERR_OPCODE;
            end else if (cmd_in == OP_STOP) begin
                // Stop typed on the switches behaves exactly like end_key.
                if (depth_q != '0) begin
                    action      = ACT_ERR;
                    action_code = ERR_BRACKET;
                end else begin
                    action = ACT_TERM;
                end
            end else if (((cmd_in == OP_CLOSE) && (depth_q == '0)) ||
                         ((cmd_in == OP_OPEN) && (depth_q == MAX_DEPTH))) begin
                action      = ACT_ERR;
                action_code = ERR_BRACKET;
            end else if (prog_addr_q == MAX_ADDR) begin
                // The last address is reserved for the stop opcode.
                action      = ACT_ERR;
                action_code = ERR_FULL;
            end else begin
                action = ACT_WRITE;
            end
        end else if (end_press) begin
            if (depth_q != '0) begin
                action      = ACT_ERR;
                action_code = ERR_BRACKET;
            end else begin
                action = ACT_TERM;
            end
        end
    end

    // NOTE: the reset is asynchronous so prog_we drops the moment resetn falls,
    // even in the middle of a write cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            prog_addr_q  <= ADDR_ONE;
            prog_wdata_q <= 4'b0000;
            prog_we_q    <= 1'b0;
            prog_len_q   <= '0;
            loading_q    <= 1'b0;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            depth_q      <= '0;
            cmd_key_q    <= 1'b0;
            end_key_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the
            // defaults below are overridden later in the same block where needed.
            cmd_key_q <= cmd_key;
            end_key_q <= end_key;
            prog_we_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_load) begin
                        state_q     <= S_LOAD;
                        prog_addr_q <= ADDR_ONE;
                        prog_len_q  <= '0;
                        depth_q     <= '0;
                        loading_q   <= 1'b1;
                        load_done_q <= 1'b0;
                        err_q       <= 1'b0;
                        err_code_q  <= 2'b00;
                    end
                end

                S_LOAD: begin
                    if (start_load) begin
                        // Restart; any press seen in this cycle is dropped.
                        prog_addr_q <= ADDR_ONE;
                        prog_len_q  <= '0;
                        depth_q     <= '0;
                        load_done_q <= 1'b0;
                        err_q       <= 1'b0;
                        err_code_q  <= 2'b00;
                    end else begin
                        case (action)
                            ACT_WRITE: begin
                                state_q      <= S_WRITE;
                                prog_we_q    <= 1'b1;
                                prog_wdata_q <= cmd_in;
                            end
                            ACT_TERM: begin
                                state_q      <= S_TERM;
                                prog_we_q    <= 1'b1;
                                prog_wdata_q <= OP_STOP;
                            end
                            ACT_ERR: begin
                                state_q    <= S_ERR;
                                loading_q  <= 1'b0;
                                err_q      <= 1'b1;
                                err_code_q <= action_code;
                            end
                            default: ;
                        endcase
                    end
                end

                S_WRITE: begin
                    // The write strobe was high this cycle; advance past it.
                    state_q     <= S_LOAD;
                    prog_addr_q <= prog_addr_q + ADDR_ONE;
                    prog_len_q  <= prog_len_q + ADDR_ONE;
                    if (prog_wdata_q == OP_OPEN) begin
                        depth_q <= depth_q + DEPTH_ONE;
                    end else if (prog_wdata_q == OP_CLOSE) begin
                        depth_q <= depth_q - DEPTH_ONE;
                    end
                end

                S_TERM: begin
                    // Stop has been written at prog_addr; address and length stay.
                    state_q     <= S_DONE;
                    loading_q   <= 1'b0;
                    load_done_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign prog_addr  = prog_addr_q;
    assign prog_wdata = prog_wdata_q;
    assign prog_we    = prog_we_q;
    assign prog_len   = prog_len_q;
    assign loading    = loading_q;
    assign load_done  = load_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// ---------------------------------------------------------------------------
// tb_bf_program_loader
//
// Small address and depth widths make the memory-full and nesting-limit
// boundaries reachable in a few presses. The stimulus side updates a
// behavioural model of the loading rules and queues each expected memory
// write; an independent monitor pops the queue whenever prog_we is seen.
// ---------------------------------------------------------------------------
module tb_bf_program_loader;

    localparam int AW   = 3;
    localparam int DW   = 2;
    localparam int MAXA = (1 << AW) - 1;
    localparam int MAXD = (1 << DW) - 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    data;
    } wr_t;

    logic          clk;
    logic          resetn;
    logic          start_load;
    logic [3:0]    cmd_in;
    logic          cmd_key;
    logic          end_key;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_wdata;
    logic          prog_we;
    logic [AW-1:0] prog_len;
    logic          loading;
    logic          load_done;
    logic          err;
    logic [1:0]    err_code;

    bf_program_loader #(.ADDR_W(AW), .DEPTH_W(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_load (start_load),
        .cmd_in     (cmd_in),
        .cmd_key    (cmd_key),
        .end_key    (end_key),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_we    (prog_we),
        .prog_len   (prog_len),
        .loading    (loading),
        .load_done  (load_done),
        .err        (err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  we_cycles = 0;
    wr_t exp_q[$];

    // Reference model state: what the loader should hold after each press.
    bit  m_active, m_done, m_err;
    int  m_code, m_addr, m_len, m_depth;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (prog_we) begin
            we_cycles++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {28'd0, prog_wdata}, 32'hDEAD);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", prog_addr, e.addr);
                check("write_data", prog_wdata, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_code = 0;
        m_addr = 1; m_len = 0; m_depth = 0;
    endtask

    task automatic model_restart();
        m_active = 1; m_done = 0; m_err = 0; m_code = 0;
        m_addr = 1; m_len = 0; m_depth = 0;
    endtask

    task automatic model_err(input int code);
        m_active = 0; m_err = 1; m_code = code;
    endtask

    task automatic model_end();
        if (m_depth != 0) begin
            model_err(3);
        end else begin
            exp_q.push_back('{addr: AW'(m_addr), data: 4'hF});
            m_active = 0;
            m_done   = 1;
        end
    endtask

    task automatic model_press(input bit c, input bit e, input logic [3:0] op);
        if (!m_active) return;
        if (c) begin
            if (op >= 4'd8 && op <= 4'd14)                               model_err(1);
            else if (op == 4'hF)                                          model_end();
            else if ((op == 4'd5 && m_depth == 0) || (op == 4'd4 && m_depth == MAXD)) model_err(3);
            else if (m_addr == MAXA)                                      model_err(2);
            else begin
                exp_q.push_back('{addr: AW'(m_addr), data: op});
                m_addr++;
                m_len++;
                if (op == 4'd4) m_depth++;
                if (op == 4'd5) m_depth--;
            end
        end else if (e) begin
            model_end();
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        tick(1);
        start_load = 1'b1;
        tick(1);
        start_load = 1'b0;
        model_restart();
        tick(1);
    endtask

    // One press: key(s) high for 'hold' cycles, then released long enough
    // for any write to finish before the next press.
    task automatic press(input bit c, input bit e, input logic [3:0] op, input int hold);
        tick(1);
        cmd_in  = op;
        cmd_key = c;
        end_key = e;
        model_press(c, e, op);
        tick(hold);
        cmd_key = 1'b0;
        end_key = 1'b0;
        cmd_in  = 4'($urandom);
        tick(2);
    endtask

    task automatic check_status(input string tag);
        tick(3);
        check({tag, "_addr"},      prog_addr, m_addr);
        check({tag, "_len"},       prog_len, m_len);
        check({tag, "_loading"},   loading, m_active);
        check({tag, "_load_done"}, load_done, m_done);
        check({tag, "_err"},       err, m_err);
        check({tag, "_err_code"},  err_code, m_code);
        check({tag, "_drained"},   exp_q.size(), 0);
    endtask

    logic [3:0] seq_a [3] = '{4'd2, 4'd2, 4'd6};
    logic [3:0] seq_b [4] = '{4'd4, 4'd2, 4'd5, 4'd5};
    logic [3:0] seq_f [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd2};

    initial begin
        int base;
        resetn = 1'b0; start_load = 1'b0; cmd_in = 4'd0; cmd_key = 1'b0; end_key = 1'b0;
        model_reset();
        tick(3);
        check("reset_we", prog_we, 0);
        check("reset_wdata", prog_wdata, 0);
        check_status("reset");
        resetn = 1'b1;

        // Presses in IDLE do nothing.
        press(1, 0, 4'd3, 1);
        press(0, 1, 4'd0, 1);
        check_status("idle_ignore");

        // Basic program followed by stop.
        do_start();
        foreach (seq_a[i]) press(1, 0, seq_a[i], 1);
        press(0, 1, 4'd0, 1);
        check_status("basic");

        // Presses in DONE are ignored; a held key writes only once.
        press(1, 0, 4'd1, 1);
        do_start();
        base = we_cycles;
        press(1, 0, 4'd1, 20);
        check("hold_single_we", we_cycles - base, 1);
        check_status("hold");

        // Too many closing brackets.
        do_start();
        foreach (seq_b[i]) press(1, 0, seq_b[i], 1);
        check_status("close_unbal");

        // End with an open bracket, then a restart from ERR.
        do_start();
        press(1, 0, 4'd4, 1);
        press(0, 1, 4'd0, 1);
        check_status("open_unbal");
        do_start();
        check_status("restart_from_err");

        // Invalid opcode.
        press(1, 0, 4'd10, 1);
        check_status("bad_opcode");

        // Memory full: six writes fit, the seventh is refused.
        do_start();
        foreach (seq_f[i]) press(1, 0, seq_f[i], 1);
        check_status("mem_full");

        // Nesting limit.
        do_start();
        repeat (MAXD + 1) press(1, 0, 4'd4, 1);
        check_status("depth_max");

        // cmd and end pressed together: cmd wins, end is lost.
        do_start();
        press(1, 1, 4'd2, 1);
        check_status("cmd_end_same");
        press(0, 1, 4'd0, 1);
        check_status("cmd_end_after");

        // Restart with a press in the same cycle: the press is dropped.
        do_start();
        press(1, 0, 4'd3, 1);
        tick(1);
        start_load = 1'b1; cmd_key = 1'b1; cmd_in = 4'd6;
        model_restart();
        tick(1);
        start_load = 1'b0; cmd_key = 1'b0;
        check_status("restart_press");

        // Stop typed on the switches.
        press(1, 0, 4'd4, 1);
        press(1, 0, 4'hF, 1);
        check_status("stop_cmd_unbal");
        do_start();
        press(1, 0, 4'd1, 1);
        press(1, 0, 4'hF, 1);
        check_status("stop_cmd_ok");

        // Reset in the middle of a write.
        do_start();
        tick(1);
        cmd_in = 4'd3; cmd_key = 1'b1;
        model_press(1, 0, 4'd3);
        tick(1);
        #1;
        check("pre_reset_we", prog_we, 1);
        resetn = 1'b0;
        #1;
        check("async_reset_we", prog_we, 0);
        check("async_reset_addr", prog_addr, 1);
        check("async_reset_len", prog_len, 0);
        cmd_key = 1'b0;
        model_reset();
        tick(2);
        resetn = 1'b1;
        check_status("after_reset");

        // Randomised programs.
        for (int r = 0; r < 40; r++) begin
            int n;
            do_start();
            n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) begin
                int sel;
                logic [3:0] op;
                logic [3:0] pick [6];
                pick = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};
                sel = $urandom_range(0, 9);
                if (sel < 6)       op = pick[$urandom_range(0, 5)];
                else if (sel < 8)  op = 4'($urandom_range(4, 5));
                else if (sel == 8) op = 4'($urandom_range(8, 14));
                else               op = 4'hF;
                sel = $urandom_range(0, 19);
                if (sel == 0)      press(1, 1, op, $urandom_range(1, 3));
                else if (sel < 3)  press(0, 1, op, $urandom_range(1, 3));
                else               press(1, 0, op, $urandom_range(1, 3));
            end
            if ($urandom_range(0, 1) == 1) press(0, 1, 4'd0, 1);
            check_status("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
